// File: rtl/fifo_ctrl.sv
// fifo_ctrl -- pointer and flag controller that turns a dual-port memory into a synchronous FIFO.
//
// Port A of the memory is used only for writes and port B only for reads. This block owns the
// write/read pointers, the occupancy count, the full/empty and threshold flags, the read-data
// valid strobe and the overflow/underflow pulses. It is the only driver of the memory's address
// and rw inputs.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   push, data_in          producer write request and write data
//   pop                    consumer read request
//   data_out, data_valid   read data (straight from DataOutB) and its valid strobe
//   full, empty            registered occupancy flags
//   almost_full/_empty     registered threshold flags (count >= AF_LEVEL / count <= AE_LEVEL)
//   count                  occupancy, 0..2**ADDR_W
//   overflow, underflow    one-cycle pulse after a rejected push / pop
//   AddrA, rwA, DataInA    memory write port
//   AddrB, rwB, DataOutB   memory read port (DataOutB is registered inside the memory)
module fifo_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] AddrA,
  output logic              rwA,
  output logic [DATA_W-1:0] DataInA,
  output logic [ADDR_W-1:0] AddrB,
  output logic              rwB,
  input  logic [DATA_W-1:0] DataOutB
);

  // Threshold levels sized to the count width so comparisons stay width-matched.
  localparam logic [ADDR_W:0] AfLevel = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AeLevel = AE_LEVEL[ADDR_W:0];

  // Pointers carry one extra wrap bit above the memory address.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic valid_q, valid_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  logic push_ok;
  logic pop_ok;

  // Accept rules. Because acceptance uses the registered flags, a push while full is refused
  // even if a pop frees a slot in the same cycle; this keeps port A from writing the word that
  // port B is reading out. Symmetrically a pop while empty is refused even alongside a push.
  always_comb begin
    push_ok = push & ~full_q;
    pop_ok  = pop & ~empty_q;
  end

  // Next-state pointers, count and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_ok};

    // Modulo subtraction on the wrap-extended pointers yields 0..2**ADDR_W directly.
    count_d  = wr_ptr_d - rd_ptr_d;

    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
               (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    afull_d  = (count_d >= AfLevel);
    aempty_d = (count_d <= AeLevel);

    // The memory registers mem[AddrB] at the same edge that accepts the pop.
    valid_d  = pop_ok;
    ovf_d    = push & full_q;
    unf_d    = pop & empty_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Memory drive. rwA is held low while reset is asserted so nothing is written then.
  always_comb begin
    AddrA   = wr_ptr_q[ADDR_W-1:0];
    DataInA = data_in;
    rwA     = push_ok & ~reset;
    AddrB   = rd_ptr_q[ADDR_W-1:0];
    rwB     = 1'b0;
  end

  // Producer/consumer outputs.
  always_comb begin
    data_out     = DataOutB;
    data_valid   = valid_q;
    full         = full_q;
    empty        = empty_q;
    almost_full  = afull_q;
    almost_empty = aempty_q;
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  // A write must never land on the word being read out in the same cycle.
  a_no_collision : assert property (@(posedge clk) disable iff (reset)
    !(rwA && pop_ok && (AddrA == AddrB)));

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [3:0] data_in;
  logic       pop;
  logic [3:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;
  logic [2:0] AddrA;
  logic       rwA;
  logic [3:0] DataInA;
  logic [2:0] AddrB;
  logic       rwB;
  logic [3:0] DataOutB;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_W  (3),
    .DATA_W  (4),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .AddrA       (AddrA),
    .rwA         (rwA),
    .DataInA     (DataInA),
    .AddrB       (AddrB),
    .rwB         (rwB),
    .DataOutB    (DataOutB)
  );

  // Behavioural model of the 8x4 memory: write on rwA, registered read of mem[AddrB].
  logic [3:0] mem [8];
  always @(posedge clk) begin
    if (rwA) mem[AddrA] <= DataInA;
    DataOutB <= mem[AddrB];
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of stored words plus accepted-op counters.
  logic [3:0] q[$];
  int         wr_cnt;
  int         rd_cnt;
  logic       e_valid, e_ovf, e_unf;
  logic [3:0] e_dout;

  // Drive one cycle of requests (called just after a falling edge), check the combinational
  // memory drive, advance the model, and return just after the next falling edge.
  task automatic apply(input logic p, input logic o, input logic [3:0] d);
    logic m_full, m_empty, pok, ook;
    m_full  = (q.size() == 8);
    m_empty = (q.size() == 0);
    pok     = p && !m_full;
    ook     = o && !m_empty;
    push    = p;
    pop     = o;
    data_in = d;
    #1;
    chk("rwA", rwA, pok);
    chk("rwB", rwB, 1'b0);
    if (pok) begin
      chk("AddrA", AddrA, wr_cnt % 8);
      chk("DataInA", DataInA, d);
    end
    if (ook) chk("AddrB", AddrB, rd_cnt % 8);
    if (ook) begin
      e_dout = q.pop_front();
      rd_cnt++;
    end
    if (pok) begin
      q.push_back(d);
      wr_cnt++;
    end
    e_valid = ook;
    e_ovf   = p && m_full;
    e_unf   = o && m_empty;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic check_model();
    chk("count", count, q.size());
    chk("full", full, q.size() == 8);
    chk("empty", empty, q.size() == 0);
    chk("almost_full", almost_full, q.size() >= 6);
    chk("almost_empty", almost_empty, q.size() <= 2);
    chk("overflow", overflow, e_ovf);
    chk("underflow", underflow, e_unf);
    chk("data_valid", data_valid, e_valid);
    if (e_valid) chk("data_out", data_out, e_dout);
  endtask

  typedef struct {
    logic       p;
    logic       o;
    logic [3:0] d;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       vld;
    logic [3:0] dout;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int bias;
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    DataOutB = 4'h0;
    push     = 1'b0;
    pop      = 1'b0;
    data_in  = 4'h0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    e_valid  = 1'b0;
    e_ovf    = 1'b0;
    e_unf    = 1'b0;
    e_dout   = 4'h0;

    // Directed vectors: fill, overflow, drain, underflow, push+pop while empty.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 1'b0, 4'(i + 1), i + 1, (i == 7), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 1'b0, 4'hF, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    for (int j = 0; j < 8; j++)
      vecs.push_back('{1'b0, 1'b1, 4'h0, 7 - j, 1'b0, (j == 7), 1'b0, 1'b0, 1'b1, 4'(j + 1)});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 1'b1, 4'hC, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});

    // Reset, then idle three cycles.
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1'b1);
    chk("rst almost_empty", almost_empty, 1'b1);
    chk("rst full", full, 1'b0);
    chk("rst almost_full", almost_full, 1'b0);
    chk("rst data_valid", data_valid, 1'b0);
    chk("rst rwA", rwA, 1'b0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst underflow", underflow, 1'b0);

    foreach (vecs[k]) begin
      apply(vecs[k].p, vecs[k].o, vecs[k].d);
      chk("vec count", count, vecs[k].cnt);
      chk("vec full", full, vecs[k].full);
      chk("vec empty", empty, vecs[k].empty);
      chk("vec overflow", overflow, vecs[k].ovf);
      chk("vec underflow", underflow, vecs[k].unf);
      chk("vec data_valid", data_valid, vecs[k].vld);
      if (vecs[k].vld) chk("vec data_out", data_out, vecs[k].dout);
      check_model();
    end

    // Wrap-around: push 5, pop 3, push 6 -> pointers cross address 7, FIFO ends full.
    for (int i = 0; i < 5; i++) begin apply(1'b1, 1'b0, 4'(i + 3)); check_model(); end
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b1, 4'h0); check_model(); end
    for (int i = 0; i < 6; i++) begin apply(1'b1, 1'b0, 4'(i + 9)); check_model(); end
    chk("wrap count", count, 8);
    chk("wrap full", full, 1'b1);
    // Push and pop together while full: pop served, push refused.
    apply(1'b1, 1'b1, 4'h1);
    check_model();
    chk("full pp count", count, 7);
    chk("full pp overflow", overflow, 1'b1);
    chk("full pp data_out", data_out, 4'h6);
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b1, 4'h0); check_model(); end
    // Push and pop together at count 4: both accepted, count unchanged.
    apply(1'b1, 1'b1, 4'h5);
    check_model();
    chk("mid pp count", count, 4);

    // Randomized traffic with shifting push bias.
    for (int n = 0; n < 400; n++) begin
      bias = (n < 100) ? 70 : (n < 200) ? 30 : (n < 300) ? 50 : 90;
      apply($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias / 2),
            4'($urandom));
      check_model();
    end

    // Drain, load five words, then reset for one cycle mid-operation.
    for (int i = 0; i < 8; i++) if (q.size() > 0) begin apply(1'b0, 1'b1, 4'h0); check_model(); end
    for (int i = 0; i < 5; i++) begin apply(1'b1, 1'b0, 4'(i + 2)); check_model(); end
    chk("pre-reset count", count, 5);
    reset = 1'b1;
    #1;
    chk("async count", count, 0);
    chk("async empty", empty, 1'b1);
    chk("async almost_empty", almost_empty, 1'b1);
    chk("async full", full, 1'b0);
    chk("async data_valid", data_valid, 1'b0);
    chk("async rwA", rwA, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    wr_cnt  = 0;
    rd_cnt  = 0;
    e_valid = 1'b0;
    e_ovf   = 1'b0;
    e_unf   = 1'b0;
    check_model();
    apply(1'b1, 1'b0, 4'hA);
    check_model();
    apply(1'b0, 1'b1, 4'h0);
    check_model();
    chk("post-reset data_out", data_out, 4'hA);
    chk("post-reset data_valid", data_valid, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
